// File: rtl/redis_cache_obi_ctrl.sv
// OBI register front-end and single-outstanding GET/PUT/DEL sequencer for the RedisCache core.
// Optional WAIT-abort watchdog is enabled with `define REDIS_CTRL_TIMEOUT_EN.
module redis_cache_obi_ctrl #(
   parameter int unsigned KeyWidth      = 32,
   parameter int unsigned ValueWidth    = 32,
   parameter int unsigned IdWidth       = 1,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  obi_req_i,
   output logic                  obi_gnt_o,
   input  logic [31:0]           obi_addr_i,
   input  logic                  obi_we_i,
   input  logic [3:0]            obi_be_i,
   input  logic [31:0]           obi_wdata_i,
   input  logic [IdWidth-1:0]    obi_aid_i,
   output logic                  obi_rvalid_o,
   output logic [31:0]           obi_rdata_o,
   output logic [IdWidth-1:0]    obi_rid_o,
   output logic                  obi_err_o,
   output logic                  core_op_valid_o,
   input  logic                  core_op_ready_i,
   output logic [1:0]            core_op_code_o,
   output logic [KeyWidth-1:0]   core_key_o,
   output logic [ValueWidth-1:0] core_value_o,
   input  logic                  core_resp_valid_i,
   input  logic                  core_resp_hit_i,
   input  logic                  core_resp_full_i,
   input  logic [ValueWidth-1:0] core_resp_value_i
);

   localparam logic [11:0] OffKey    = 12'h000;
   localparam logic [11:0] OffWval   = 12'h004;
   localparam logic [11:0] OffCmd    = 12'h008;
   localparam logic [11:0] OffStatus = 12'h00C;
   localparam logic [11:0] OffRval   = 12'h014;
   localparam logic [1:0]  OpGet     = 2'd1;
   localparam logic [1:0]  OpPut     = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

   state_e                state_q, state_d;
   logic                  busy;
   logic                  launch, resp_take, tmo_hit;
   logic [11:0]           off;
   logic [KeyWidth-1:0]   key_q;
   logic [ValueWidth-1:0] wval_q, rval_q;
   logic [1:0]            op_q;
   logic                  done_q, hit_q, full_q, tmo_q;
   logic [31:0]           status, rdata_d;
   logic                  err_d;
   logic                  rvalid_q, err_q;
   logic [31:0]           rdata_q;
   logic [IdWidth-1:0]    rid_q;

   function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [3:0] be);
      logic [31:0] res;
      res = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
      return res;
   endfunction

   assign off       = obi_addr_i[11:0];
   assign obi_gnt_o = obi_req_i;
   // DONE is not busy, so a new CMD may launch straight out of it without being lost.
   assign launch    = obi_req_i && obi_we_i && !busy && off == OffCmd && obi_be_i[0] &&
                      obi_wdata_i[1:0] != 2'd0;
   assign resp_take = core_resp_valid_i &&
                      (state_q == S_WAIT || (state_q == S_ISSUE && core_op_ready_i));

`ifdef REDIS_CTRL_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)                                       cnt_q <= '0;
      else if (state_d == S_ISSUE && state_q != S_ISSUE) cnt_q <= '0;
      else if (busy)                                   cnt_q <= cnt_q + 1'b1;
   end

   assign tmo_hit = busy && !resp_take && cnt_q == CntW'(TimeoutCycles - 1);
`else
   logic unused_tmo;
   assign unused_tmo = (TimeoutCycles == 0);
   assign tmo_hit    = 1'b0;
`endif

   logic unused_addr;
   assign unused_addr = ^obi_addr_i[31:12];

   // FSM: state register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (launch) state_d = S_ISSUE;
         S_ISSUE: if (resp_take || tmo_hit)   state_d = S_DONE;
                  else if (core_op_ready_i)   state_d = S_WAIT;
         S_WAIT:  if (resp_take || tmo_hit)   state_d = S_DONE;
         S_DONE:  state_d = launch ? S_ISSUE : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy            = (state_q == S_ISSUE) || (state_q == S_WAIT);
      core_op_valid_o = (state_q == S_ISSUE);
   end

   assign core_op_code_o = op_q;
   assign core_key_o     = key_q;
   assign core_value_o   = wval_q;

   assign status = {22'd0, op_q, 3'd0, tmo_q, full_q, hit_q, done_q, busy};

   always_comb begin
      rdata_d = 32'd0;
      err_d   = 1'b0;
      case (off)
         OffKey:    begin rdata_d = 32'(key_q);  err_d = obi_we_i && busy; end
         OffWval:   begin rdata_d = 32'(wval_q); err_d = obi_we_i && busy; end
         OffCmd:    err_d = obi_we_i && busy;
         OffStatus: rdata_d = status;
         OffRval:   rdata_d = 32'(rval_q);
         default:   err_d = 1'b1;
      endcase
      if (obi_we_i) rdata_d = 32'd0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         rid_q    <= '0;
         key_q    <= '0;
         wval_q   <= '0;
         rval_q   <= '0;
         op_q     <= '0;
         done_q   <= 1'b0;
         hit_q    <= 1'b0;
         full_q   <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         rvalid_q <= obi_req_i;
         if (obi_req_i) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
            rid_q   <= obi_aid_i;
         end
         if (obi_req_i && obi_we_i && !busy && off == OffKey)
            key_q <= KeyWidth'(be_merge(32'(key_q), obi_wdata_i, obi_be_i));
         if (obi_req_i && obi_we_i && !busy && off == OffWval)
            wval_q <= ValueWidth'(be_merge(32'(wval_q), obi_wdata_i, obi_be_i));
         if (launch) begin
            op_q   <= obi_wdata_i[1:0];
            done_q <= 1'b0;
            hit_q  <= 1'b0;
            full_q <= 1'b0;
            tmo_q  <= 1'b0;
         end
         if (resp_take) begin
            done_q <= 1'b1;
            hit_q  <= core_resp_hit_i;
            full_q <= core_resp_full_i && op_q == OpPut;
            rval_q <= (op_q == OpGet && core_resp_hit_i) ? core_resp_value_i : '0;
         end else if (tmo_hit) begin
            done_q <= 1'b1;
            tmo_q  <= 1'b1;
            hit_q  <= 1'b0;
            full_q <= 1'b0;
            rval_q <= '0;
         end
      end
   end

   assign obi_rvalid_o = rvalid_q;
   assign obi_rdata_o  = rdata_q;
   assign obi_err_o    = err_q;
   assign obi_rid_o    = rid_q;

endmodule

// File: tb/tb_redis_cache_obi_ctrl.sv
// Directed + randomized bench for redis_cache_obi_ctrl against a transaction-level register model.
// Honors REDIS_CTRL_TIMEOUT_EN to pick the watchdog or the wait-forever scenario.
module tb_redis_cache_obi_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        obi_req_i, obi_gnt_o, obi_we_i;
   logic [31:0] obi_addr_i, obi_wdata_i, obi_rdata_o;
   logic [3:0]  obi_be_i;
   logic [0:0]  obi_aid_i, obi_rid_o;
   logic        obi_rvalid_o, obi_err_o;
   logic        core_op_valid_o, core_op_ready_i;
   logic [1:0]  core_op_code_o;
   logic [31:0] core_key_o, core_value_o, core_resp_value_i;
   logic        core_resp_valid_i, core_resp_hit_i, core_resp_full_i;

   always #5 clk_i = ~clk_i;

   redis_cache_obi_ctrl #(.KeyWidth(32), .ValueWidth(32), .IdWidth(1), .TimeoutCycles(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
      .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
      .obi_aid_i(obi_aid_i), .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o),
      .obi_rid_o(obi_rid_o), .obi_err_o(obi_err_o),
      .core_op_valid_o(core_op_valid_o), .core_op_ready_i(core_op_ready_i),
      .core_op_code_o(core_op_code_o), .core_key_o(core_key_o), .core_value_o(core_value_o),
      .core_resp_valid_i(core_resp_valid_i), .core_resp_hit_i(core_resp_hit_i),
      .core_resp_full_i(core_resp_full_i), .core_resp_value_i(core_resp_value_i)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // transaction-level model of the software-visible state
   logic [31:0] m_key, m_wval, m_rval;
   logic [1:0]  m_op;
   bit          m_done, m_hit, m_full, m_tmo, m_busy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_key = 0; m_wval = 0; m_rval = 0; m_op = 0;
      m_done = 0; m_hit = 0; m_full = 0; m_tmo = 0; m_busy = 0;
   endtask

   function automatic logic [31:0] m_status();
      return (32'(m_op) << 8) + (32'(m_tmo) << 4) + (32'(m_full) << 3) +
             (32'(m_hit) << 2) + (32'(m_done) << 1) + 32'(m_busy);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   function automatic bit valid_off(input logic [11:0] off);
      return off == 12'h000 || off == 12'h004 || off == 12'h008 || off == 12'h00C || off == 12'h014;
   endfunction

   task automatic bus(input logic [11:0] off, input logic we, input logic [3:0] be,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er);
      logic [0:0] id;
      @(negedge clk_i);
      chk("rvalid_idle", 32'(obi_rvalid_o), 32'd0);
      id = 1'($urandom);
      obi_req_i = 1; obi_addr_i = 32'h2000_1000 | {20'd0, off};
      obi_we_i = we; obi_be_i = be; obi_wdata_i = wd; obi_aid_i = id;
      #1 chk("gnt", 32'(obi_gnt_o), 32'd1);
      @(negedge clk_i);
      obi_req_i = 0; obi_we_i = 0;
      chk("rvalid", 32'(obi_rvalid_o), 32'd1);
      chk("rid", 32'(obi_rid_o), 32'(id));
      rd = obi_rdata_o; er = obi_err_o;
   endtask

   task automatic wr(input logic [11:0] off, input logic [3:0] be, input logic [31:0] d);
      logic [31:0] rd; logic er; bit exp_err; bit ctl;
      ctl = off == 12'h000 || off == 12'h004 || off == 12'h008;
      exp_err = !valid_off(off) || (m_busy && ctl);
      bus(off, 1'b1, be, d, rd, er);
      chk($sformatf("wr_err_%03h", off), 32'(er), 32'(exp_err));
      if (!exp_err) begin
         if (off == 12'h000) m_key = merge(m_key, d, be);
         if (off == 12'h004) m_wval = merge(m_wval, d, be);
         if (off == 12'h008 && be[0] && d[1:0] != 0) begin
            m_op = d[1:0]; m_done = 0; m_hit = 0; m_full = 0; m_tmo = 0; m_busy = 1;
         end
      end
   endtask

   task automatic rd(input logic [11:0] off);
      logic [31:0] r, exp; logic er;
      exp = 0;
      if (off == 12'h000) exp = m_key;
      if (off == 12'h004) exp = m_wval;
      if (off == 12'h00C) exp = m_status();
      if (off == 12'h014) exp = m_rval;
      bus(off, 1'b0, 4'hF, 32'd0, r, er);
      chk($sformatf("rd_data_%03h", off), r, exp);
      chk($sformatf("rd_err_%03h", off), 32'(er), 32'(!valid_off(off)));
   endtask

   task automatic chk_issue();
      chk("op_valid", 32'(core_op_valid_o), 32'd1);
      chk("op_code", 32'(core_op_code_o), 32'(m_op));
      chk("op_key", core_key_o, m_key);
      chk("op_value", core_value_o, m_wval);
   endtask

   // Called at the negedge of the first ISSUE cycle; returns once the DUT is in DONE.
   task automatic core_run(input int rdy_dly, input int rsp_dly, input bit h, input bit f,
                           input logic [31:0] v);
      int nvalid;
      nvalid = 0;
      for (int i = 0; i < rdy_dly; i++) begin
         chk_issue(); nvalid++; @(negedge clk_i);
      end
      chk_issue(); nvalid++;
      chk("valid_cycles", 32'(nvalid), 32'(rdy_dly + 1));
      core_op_ready_i = 1;
      if (rsp_dly == 0) begin
         core_resp_valid_i = 1; core_resp_hit_i = h; core_resp_full_i = f; core_resp_value_i = v;
      end
      @(negedge clk_i);
      core_op_ready_i = 0; core_resp_valid_i = 0;
      chk("op_valid_drop", 32'(core_op_valid_o), 32'd0);
      if (rsp_dly > 0) begin
         for (int i = 1; i < rsp_dly; i++) @(negedge clk_i);
         core_resp_valid_i = 1; core_resp_hit_i = h; core_resp_full_i = f; core_resp_value_i = v;
         @(negedge clk_i);
         core_resp_valid_i = 0;
      end
      m_busy = 0; m_done = 1; m_hit = h;
      m_full = (m_op == 2) && f;
      m_rval = (m_op == 1 && h) ? v : 32'd0;
   endtask

   task automatic stale_resp();
      @(negedge clk_i);
      core_resp_valid_i = 1; core_resp_hit_i = 1; core_resp_full_i = 1;
      core_resp_value_i = 32'hBAD0_BAD0;
      @(negedge clk_i);
      core_resp_valid_i = 0;
   endtask

   initial begin
      obi_req_i = 0; obi_we_i = 0; obi_be_i = 0; obi_addr_i = 0; obi_wdata_i = 0; obi_aid_i = 0;
      core_op_ready_i = 0; core_resp_valid_i = 0; core_resp_hit_i = 0; core_resp_full_i = 0;
      core_resp_value_i = 0;
      m_reset();
      rst_i = 1;
      repeat (3) @(negedge clk_i);
      rst_i = 0;
      chk("rst_op_valid", 32'(core_op_valid_o), 32'd0);
      chk("rst_rvalid", 32'(obi_rvalid_o), 32'd0);
      rd(12'h00C);
      rd(12'h014);

      // PUT 0xAB -> 0xDEADBEEF, core ready on the second cycle
      wr(12'h000, 4'hF, 32'h0000_00AB);
      wr(12'h004, 4'hF, 32'hDEAD_BEEF);
      wr(12'h008, 4'h1, 32'd2);
      core_run(1, 1, 1'b0, 1'b0, 32'd0);
      chk("put_status_const", m_status(), 32'h0000_0202);
      rd(12'h00C);

      // GET hit; busy-time write rejection and invalid offsets
      wr(12'h008, 4'h1, 32'd1);
      rd(12'h00C);
      wr(12'h000, 4'hF, 32'h0000_0055);
      wr(12'h004, 4'hF, 32'h1234_5678);
      rd(12'h000);
      rd(12'h020);
      rd(12'h010);
      core_run(0, 2, 1'b1, 1'b0, 32'hDEAD_BEEF);
      rd(12'h00C);
      rd(12'h014);
      stale_resp();
      rd(12'h00C);
      rd(12'h014);

      // PUT rejected as full; ignored opcode 0 and RO writes
      wr(12'h008, 4'h1, 32'd2);
      core_run(0, 0, 1'b0, 1'b1, 32'd0);
      rd(12'h00C);
      wr(12'h008, 4'h1, 32'd0);
      wr(12'h00C, 4'hF, 32'hFFFF_FFFF);
      wr(12'h014, 4'hF, 32'hFFFF_FFFF);
      wr(12'h030, 4'hF, 32'hFFFF_FFFF);
      chk("no_launch_op0", 32'(core_op_valid_o), 32'd0);
      rd(12'h00C);

      // back-to-back reads
      @(negedge clk_i);
      obi_req_i = 1; obi_we_i = 0; obi_addr_i = 32'h2000_1000; obi_aid_i = 1'b0;
      @(negedge clk_i);
      chk("b2b_rvalid0", 32'(obi_rvalid_o), 32'd1);
      chk("b2b_rdata0", obi_rdata_o, m_key);
      chk("b2b_rid0", 32'(obi_rid_o), 32'd0);
      obi_addr_i = 32'h2000_1004; obi_aid_i = 1'b1;
      @(negedge clk_i);
      obi_req_i = 0;
      chk("b2b_rvalid1", 32'(obi_rvalid_o), 32'd1);
      chk("b2b_rdata1", obi_rdata_o, m_wval);
      chk("b2b_rid1", 32'(obi_rid_o), 32'd1);

      // randomized operations with masked key writes and random core latency
      for (int it = 0; it < 24; it++) begin
         logic [1:0] op;
         op = 2'($urandom_range(1, 3));
         wr(12'h000, 4'($urandom), $urandom);
         wr(12'h004, 4'hF, $urandom);
         wr(12'h008, 4'h1, {30'($urandom), op});
         core_run(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), $urandom);
         rd(12'h00C);
         rd(12'h014);
         rd(12'h000);
      end

`ifdef REDIS_CTRL_TIMEOUT_EN
      // watchdog: no response -> DONE 16 cycles after entering ISSUE
      wr(12'h008, 4'h1, 32'd1);
      for (int i = 0; i < 15; i++) @(negedge clk_i);
      chk("tmo_still_valid", 32'(core_op_valid_o), 32'd1);
      @(negedge clk_i);
      chk("tmo_valid_drop", 32'(core_op_valid_o), 32'd0);
      m_busy = 0; m_done = 1; m_tmo = 1; m_hit = 0; m_full = 0; m_rval = 0;
      rd(12'h00C);
      stale_resp();
      rd(12'h00C);
      rd(12'h014);
`else
      // no watchdog: the request stays pending indefinitely
      wr(12'h008, 4'h1, 32'd1);
      repeat (40) @(negedge clk_i);
      chk("no_tmo_valid", 32'(core_op_valid_o), 32'd1);
      rd(12'h00C);
      @(negedge clk_i);
      core_run(0, 0, 1'b0, 1'b0, 32'd0);
      rd(12'h00C);
`endif

      // reset in the middle of WAIT
      wr(12'h008, 4'h1, 32'd3);
      core_op_ready_i = 1;
      @(negedge clk_i);
      core_op_ready_i = 0;
      chk("wait_valid", 32'(core_op_valid_o), 32'd0);
      rd(12'h00C);
      @(negedge clk_i);
      rst_i = 1;
      @(negedge clk_i);
      rst_i = 0;
      m_reset();
      chk("rst_wait_valid", 32'(core_op_valid_o), 32'd0);
      rd(12'h00C);
      stale_resp();
      rd(12'h00C);
      rd(12'h000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
